// File: rtl/rename_pkg.sv
// Shared rename-path types: physical register index width and the release request record.
package rename_pkg;
  localparam int PHYS_REGS_DEFAULT = 64;
  localparam int PHYS_IDX_W        = 6;
  typedef logic [PHYS_IDX_W-1:0] phys_idx_t;
  localparam phys_idx_t PHYS_ZERO = '0;

  typedef struct packed {
    logic      vld;
    phys_idx_t phys;
  } rel_req_t;
endpackage

// File: rtl/release_fifo.sv
// 2-write/1-read circular FIFO of physical register indices; drains one entry
// whenever non-empty, since the free list never back-pressures.
module release_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 6,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr0_en,
  input  logic [W-1:0]  wr0_data,
  input  logic          wr1_en,
  input  logic [W-1:0]  wr1_data,
  output logic          rd_vld,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt_next;

  assign rd_vld   = (count != '0);
  assign rd_data  = rd_vld ? mem[head] : '0;
  assign cnt_next = count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(rd_vld);
      tail  <= tail + PW'(wr0_en) + PW'(wr1_en);
      count <= cnt_next;
    end
  end

  // Second write lands right behind the first, or at tail if the first slot was unused.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[tail] <= wr0_data;
    if (wr1_en) mem[tail + PW'(wr0_en)] <= wr1_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) + int'(wr0_en) + int'(wr1_en) - int'(rd_vld)) <= DEPTH);
endmodule

// File: rtl/phys_release_queue.sv
// Collects commit/squash physical-register releases and feeds the free list one per cycle.
// Optional duplicate filtering via `define RELEASE_DUP_CHECK_EN.
module phys_release_queue
  import rename_pkg::*;
#(
  parameter  int PHYS_REGS = PHYS_REGS_DEFAULT,
  parameter  int DEPTH     = 8,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          commit_valid,
  input  phys_idx_t     commit_phys,
  output logic          commit_ready,
  input  logic          squash_valid,
  input  phys_idx_t     squash_phys,
  output logic          squash_ready,
  output logic          free_en,
  output phys_idx_t     free_phys,
  output logic [CW-1:0] count,
  output logic          dup_err
);
  if (PHYS_REGS > (1 << PHYS_IDX_W) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
    $error("phys_release_queue: bad PHYS_REGS/DEPTH");

  rel_req_t cmt, sqs;
  logic     cmt_fire, sqs_fire, wr0_en, wr1_en;

  // Space comes from registered count only; commit wins the last slot.
  assign commit_ready = (count < CW'(DEPTH));
  assign squash_ready = (count <= CW'(DEPTH - 2)) || ((count == CW'(DEPTH - 1)) && !commit_valid);
  assign cmt_fire     = commit_valid && commit_ready;
  assign sqs_fire     = squash_valid && squash_ready;
  assign cmt          = '{vld: cmt_fire && (commit_phys != PHYS_ZERO), phys: commit_phys};
  assign sqs          = '{vld: sqs_fire && (squash_phys != PHYS_ZERO), phys: squash_phys};

`ifdef RELEASE_DUP_CHECK_EN
  logic [PHYS_REGS-1:0] pending;
  logic                 cmt_hit, sqs_hit;

  assign cmt_hit = pending[cmt.phys];
  assign sqs_hit = pending[sqs.phys] || (cmt_fire && (commit_phys == squash_phys));
  assign wr0_en  = cmt.vld && !cmt_hit;
  assign wr1_en  = sqs.vld && !sqs_hit;

  // Dequeued and enqueued indices never coincide: a pending index is always dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      dup_err <= 1'b0;
    end else begin
      if (free_en) pending[free_phys] <= 1'b0;
      if (wr0_en)  pending[cmt.phys]  <= 1'b1;
      if (wr1_en)  pending[sqs.phys]  <= 1'b1;
      dup_err <= (cmt.vld && cmt_hit) || (sqs.vld && sqs_hit);
    end
  end
`else
  assign wr0_en  = cmt.vld;
  assign wr1_en  = sqs.vld;
  assign dup_err = 1'b0;
`endif

  release_fifo #(.DEPTH(DEPTH), .W(PHYS_IDX_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (wr0_en),
    .wr0_data (cmt.phys),
    .wr1_en   (wr1_en),
    .wr1_data (sqs.phys),
    .rd_vld   (free_en),
    .rd_data  (free_phys),
    .count    (count)
  );
endmodule

// File: doc/phys_release_queue.md
Name: phys_release_queue

Overview:
- Producer side of the physical-register free path: collects physical registers being released by commit and by squash, buffers them, and drives the free list's one-per-cycle free_en/free_phys interface.
- Commit releases the stale (old) mapping of a retiring rd write; squash releases the new mapping of a flushed instruction.
- Absorbs up to two releases per cycle and drains one per cycle.

Parameters:
- PHYS_REGS, 64, number of physical registers; index width is $clog2(PHYS_REGS) = 6.
- DEPTH, 8, queue entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- commit_valid  in  1  commit release request
- commit_phys  in  6  old physical reg freed at commit
- commit_ready  out  1  commit request accepted this cycle when valid&ready
- squash_valid  in  1  squash release request
- squash_phys  in  6  new physical reg of squashed instruction
- squash_ready  out  1  squash request accepted this cycle when valid&ready
- free_en  out  1  to free list: enqueue free_phys this cycle
- free_phys  out  6  register returned to free list
- count  out  $clog2(DEPTH)+1  occupied entries
- dup_err  out  1  duplicate release detected (feature only, else 0)

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. While rst_n=0: head=tail=0, count=0, free_en=0, free_phys=0, dup_err=0. Entry contents are don't-care. Reset mid-operation silently discards queued entries, because the free list re-initialises concurrently.
- Space: space = DEPTH - count, computed from registered count only. A same-cycle dequeue does not create space.
- commit_ready = (space >= 1).
- squash_ready = (space >= 2) || (space == 1 && !commit_valid). Commit has priority. ready may depend on commit_valid but never on squash_valid.
- Enqueue order within one cycle: commit entry first at tail, then squash entry at tail+1.
- Physical reg 0 is never enqueued. A request with phys==0 still completes its handshake but writes no entry and does not advance tail.
- Dequeue: free_en = (count != 0); free_phys = queue[head] when count != 0, else 0. Both are combinational from registered state, with no dependence on the inputs. The free list never back-pressures, so head advances every cycle free_en=1.
- Latency: an entry accepted at edge N appears on free_en/free_phys no earlier than the cycle after edge N. It is later only if older entries are ahead of it. Order is strictly FIFO.
- Count update: count_next = count + enq_n - (free_en ? 1 : 0), where enq_n is 0..2. Two enqueues plus one dequeue gives +1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Full (count=DEPTH): both readies are 0, and free_en=1 drains one entry.
- Empty (count=0): free_en=0, and an accepted request is not bypassed to the output in the same cycle.
- count never exceeds DEPTH. An overflow or underflow is a design error, flagged by assertion.

Optional Feature:
- Macro RELEASE_DUP_CHECK_EN.
- When defined:
  - Keep a PHYS_REGS-bit pending bitmap; a bit is set on enqueue and cleared on dequeue.
  - An accepted nonzero request whose phys is already pending is dropped (no entry written).
  - Same-cycle commit_phys==squash_phys (nonzero) enqueues only the commit entry.
  - Each drop raises dup_err for exactly the following cycle (registered pulse).
  - The bitmap is cleared on reset.
- When undefined: no bitmap, duplicates are enqueued normally, dup_err is tied 0.

Decomposition:
- Shared package rename_pkg:
  - PHYS_REGS_DEFAULT = 64
  - PHYS_IDX_W = 6
  - typedef phys_idx_t = logic [PHYS_IDX_W-1:0]
  - PHYS_ZERO = '0
- The free list and rename logic use the same package.
- One natural sub-module, release_fifo: a 2-write/1-read circular FIFO holding pointers, count and storage. The top level contains the ready logic, zero filtering and duplicate check.

Test Plan:
- Reset, then commit_phys=5 accepted at edge 1 -> free_en=1, free_phys=5 in cycle after edge 1; count returns to 0 the cycle after.
- Same cycle commit=7, squash=9 with count=0 -> both ready; outputs 7 then 9 on consecutive cycles; count peaks at 2.
- Fill to 8 (DEPTH=8) with both ports, no zeros -> at count=8 both readies 0; at count=7 with commit_valid=1, squash_ready=0; entries drain in order across pointer wrap.
- commit_phys=0 and squash_phys=0 asserted for one cycle -> both handshakes complete, count unchanged, free_en stays 0.
- Queue holding 3 entries, rst_n pulled low between edges -> free_en and count go to 0 immediately without a clock edge; after release, a new request for 12 emerges as the next free_phys.
- With RELEASE_DUP_CHECK_EN: enqueue 20, then enqueue 20 again while pending -> second dropped, dup_err=1 for one cycle, free_phys=20 appears once. Without the macro, 20 appears twice and dup_err=0.
